// File: rtl/opl3_pkg.sv
// Shared OPL3 definitions: register-file data width, the host-port write request
// type used by opl3_host_drv, and a small constant helper for parameter sizing.
package opl3_pkg;

  localparam int unsigned REG_FILE_DATA_WIDTH = 8;

  // Host-port register write: bank selects port pair {bank,0}/{bank,1}.
  typedef struct packed {
    logic                           bank;
    logic [REG_FILE_DATA_WIDTH-1:0] address;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } opl3_host_req_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/opl3_host_drv.sv
// opl3_host_drv: host-side bus initiator for the OPL3 host port (clk_host domain).
// Turns register writes into an address strobe on port {bank,0} followed by a data
// strobe on port {bank,1}, with recovery gaps after each, and turns status reads into
// a port-0 read strobe whose sampled din is returned on rd_data with a rd_valid pulse.
//
// Ports:
//   clk_host, reset            clock, synchronous active-high reset
//   req_valid/req_ready/req    write request handshake and {bank,address,data}
//   rd_req_valid/rd_req_ready  status read request handshake
//   rd_valid/rd_data           one-cycle read result pulse and captured status
//   busy                       sequence in progress
//   cs_n/wr_n/rd_n/address/dout  registered bus outputs, din bus read data
//
// Optional feature: define OPL3_HOST_ADDR_CACHE_EN to skip the address phase when
// {bank,address} matches the last completed address phase.
module opl3_host_drv
  import opl3_pkg::*;
#(
  parameter int unsigned WR_PULSE_CYCLES = 2,
  parameter int unsigned ADDR_GAP_CYCLES = 4,
  parameter int unsigned DATA_GAP_CYCLES = 8
) (
  input  logic                           clk_host,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  opl3_host_req_t                 req,
  input  logic                           rd_req_valid,
  output logic                           rd_req_ready,
  output logic                           rd_valid,
  output logic [REG_FILE_DATA_WIDTH-1:0] rd_data,
  output logic                           busy,
  output logic                           cs_n,
  output logic                           wr_n,
  output logic                           rd_n,
  output logic [1:0]                     address,
  output logic [REG_FILE_DATA_WIDTH-1:0] dout,
  input  logic [REG_FILE_DATA_WIDTH-1:0] din
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StAddrStb = 3'd1;
  localparam logic [2:0] StAddrGap = 3'd2;
  localparam logic [2:0] StDataStb = 3'd3;
  localparam logic [2:0] StDataGap = 3'd4;
  localparam logic [2:0] StRdStb   = 3'd5;

  localparam int unsigned MaxCycles =
    max_u(WR_PULSE_CYCLES, max_u(ADDR_GAP_CYCLES, DATA_GAP_CYCLES));
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  // Counter holds (remaining cycles - 1); gap loads only matter when the gap exists.
  localparam logic [CntW-1:0] PulseLd   = CntW'(WR_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] AddrGapLd =
    (ADDR_GAP_CYCLES == 0) ? '0 : CntW'(ADDR_GAP_CYCLES - 1);
  localparam logic [CntW-1:0] DataGapLd =
    (DATA_GAP_CYCLES == 0) ? '0 : CntW'(DATA_GAP_CYCLES - 1);

  logic [2:0]                     r_state, w_state;
  logic [CntW-1:0]                r_cnt, w_cnt;
  opl3_host_req_t                 r_req, w_req;
  logic                           r_cs_n, w_cs_n;
  logic                           r_wr_n, w_wr_n;
  logic                           r_rd_n, w_rd_n;
  logic [1:0]                     r_address, w_address;
  logic [REG_FILE_DATA_WIDTH-1:0] r_dout, w_dout;
  logic [REG_FILE_DATA_WIDTH-1:0] r_rd_data, w_rd_data;
  logic                           r_rd_valid, w_rd_valid;
  logic                           w_last;
  logic                           w_cache_hit;
  logic                           w_addr_done;

`ifdef OPL3_HOST_ADDR_CACHE_EN
  logic [REG_FILE_DATA_WIDTH:0]   r_cache_key;
  logic                           r_cache_vld;

  assign w_cache_hit = r_cache_vld && (r_cache_key == {req.bank, req.address});
`else
  assign w_cache_hit = 1'b0;
`endif

  assign w_last = (r_cnt == '0);

  always_comb begin
    w_state     = r_state;
    w_cnt       = w_last ? r_cnt : r_cnt - CntW'(1);
    w_req       = r_req;
    w_cs_n      = r_cs_n;
    w_wr_n      = r_wr_n;
    w_rd_n      = r_rd_n;
    w_address   = r_address;
    w_dout      = r_dout;
    w_rd_data   = r_rd_data;
    w_rd_valid  = 1'b0;
    w_addr_done = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_req  = req;
          w_cs_n = 1'b0;
          w_wr_n = 1'b0;
          w_cnt  = PulseLd;
          if (w_cache_hit) begin
            w_state   = StDataStb;
            w_address = {req.bank, 1'b1};
            w_dout    = req.data;
          end else begin
            w_state   = StAddrStb;
            w_address = {req.bank, 1'b0};
            w_dout    = req.address;
          end
        end else if (rd_req_valid) begin
          w_state   = StRdStb;
          w_address = 2'b00;
          w_cs_n    = 1'b0;
          w_rd_n    = 1'b0;
          w_cnt     = PulseLd;
        end
      end

      StAddrStb, StAddrGap: begin
        // Bus is driven from the latched request only.
        w_address = {r_req.bank, 1'b0};
        w_dout    = r_req.address;
        if (w_last) begin
          w_addr_done = (r_state == StAddrStb);
          if (r_state == StAddrStb && ADDR_GAP_CYCLES != 0) begin
            w_state = StAddrGap;
            w_cs_n  = 1'b1;
            w_wr_n  = 1'b1;
            w_cnt   = AddrGapLd;
          end else begin
            w_state   = StDataStb;
            w_address = {r_req.bank, 1'b1};
            w_dout    = r_req.data;
            w_cs_n    = 1'b0;
            w_wr_n    = 1'b0;
            w_cnt     = PulseLd;
          end
        end
      end

      StDataStb: begin
        if (w_last) begin
          w_cs_n = 1'b1;
          w_wr_n = 1'b1;
          if (DATA_GAP_CYCLES != 0) begin
            w_state = StDataGap;
            w_cnt   = DataGapLd;
          end else begin
            w_state = StIdle;
          end
        end
      end

      StDataGap: begin
        if (w_last) w_state = StIdle;
      end

      StRdStb: begin
        if (w_last) begin
          w_state    = StIdle;
          w_cs_n     = 1'b1;
          w_rd_n     = 1'b1;
          w_rd_data  = din;
          w_rd_valid = 1'b1;
        end
      end

      default: begin
        w_state = StIdle;
        w_cs_n  = 1'b1;
        w_wr_n  = 1'b1;
        w_rd_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_host) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_req      <= '0;
      r_cs_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_address  <= 2'b00;
      r_dout     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_req      <= w_req;
      r_cs_n     <= w_cs_n;
      r_wr_n     <= w_wr_n;
      r_rd_n     <= w_rd_n;
      r_address  <= w_address;
      r_dout     <= w_dout;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
    end
  end

`ifdef OPL3_HOST_ADDR_CACHE_EN
  // Only the valid bit is reset; the key is meaningless while invalid.
  always_ff @(posedge clk_host) begin
    if (reset) begin
      r_cache_vld <= 1'b0;
    end else if (w_addr_done) begin
      r_cache_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk_host) begin
    if (!reset && w_addr_done) begin
      r_cache_key <= {r_req.bank, r_req.address};
    end
  end
`endif

  assign req_ready    = (r_state == StIdle) && !reset;
  assign rd_req_ready = (r_state == StIdle) && !req_valid && !reset;
  assign busy         = (r_state != StIdle);
  assign cs_n         = r_cs_n;
  assign wr_n         = r_wr_n;
  assign rd_n         = r_rd_n;
  assign address      = r_address;
  assign dout         = r_dout;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_opl3_host_drv.sv
// Self-checking bench for opl3_host_drv. Expected per-cycle bus words are queued when
// a request is accepted and compared by a monitor on each falling edge. A second
// instance with zero gaps covers the adjacent-strobe case.
module tb_opl3_host_drv;
  import opl3_pkg::*;

  localparam int unsigned P = 2;
  localparam int unsigned A = 4;
  localparam int unsigned D = 8;
`ifdef OPL3_HOST_ADDR_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  logic           clk_host = 1'b0;
  logic           reset;
  logic           req_valid, req_ready, rd_req_valid, rd_req_ready;
  opl3_host_req_t req;
  logic           rd_valid, busy, cs_n, wr_n, rd_n;
  logic [7:0]     rd_data, dout, din;
  logic [1:0]     address;

  logic           z_req_valid, z_req_ready, z_rd_req_ready;
  opl3_host_req_t z_req;
  logic           z_rd_valid, z_busy, z_cs_n, z_wr_n, z_rd_n;
  logic [7:0]     z_rd_data, z_dout;
  logic [1:0]     z_address;

  always #5 clk_host = ~clk_host;

  opl3_host_drv #(
    .WR_PULSE_CYCLES(P), .ADDR_GAP_CYCLES(A), .DATA_GAP_CYCLES(D)
  ) u_dut (
    .clk_host(clk_host), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req(req), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .cs_n(cs_n), .wr_n(wr_n),
    .rd_n(rd_n), .address(address), .dout(dout), .din(din)
  );

  opl3_host_drv #(
    .WR_PULSE_CYCLES(P), .ADDR_GAP_CYCLES(0), .DATA_GAP_CYCLES(0)
  ) u_dut_zero (
    .clk_host(clk_host), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req(z_req), .rd_req_valid(1'b0), .rd_req_ready(z_rd_req_ready),
    .rd_valid(z_rd_valid), .rd_data(z_rd_data), .busy(z_busy), .cs_n(z_cs_n),
    .wr_n(z_wr_n), .rd_n(z_rd_n), .address(z_address), .dout(z_dout), .din(8'h00)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk_host) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // {busy, cs_n, wr_n, rd_n, rd_valid, address, dout, rd_data}
  function automatic logic [22:0] bw(input logic b, input logic c, input logic w,
                                     input logic r, input logic v, input logic [1:0] ad,
                                     input logic [7:0] dq, input logic [7:0] rq);
    return {b, c, w, r, v, ad, dq, rq};
  endfunction

  logic [22:0] exp_q[$];
  logic [7:0]  m_dout = 8'h00;
  logic [7:0]  m_rdd  = 8'h00;
  logic        m_cvld = 1'b0;
  logic [8:0]  m_ckey = 9'h000;

  always @(negedge clk_host) begin
    if (exp_q.size() > 0) begin
      logic [22:0] e;
      e = exp_q.pop_front();
      check_eq("bus", 32'(bw(busy, cs_n, wr_n, rd_n, rd_valid, address, dout, rd_data)),
               32'(e));
    end
  end

  // Queues the write trace; len = cycles from accept to the next possible accept.
  task automatic push_write(input logic bank, input logic [7:0] a, input logic [7:0] d,
                            output int len);
    bit hit;
    hit = CacheEn && m_cvld && (m_ckey == {bank, a});
    len = 0;
    if (!hit) begin
      repeat (P) begin exp_q.push_back(bw(1, 0, 0, 1, 0, {bank, 1'b0}, a, m_rdd)); len++; end
      repeat (A) begin exp_q.push_back(bw(1, 1, 1, 1, 0, {bank, 1'b0}, a, m_rdd)); len++; end
      m_cvld = 1'b1;
      m_ckey = {bank, a};
    end
    repeat (P) begin exp_q.push_back(bw(1, 0, 0, 1, 0, {bank, 1'b1}, d, m_rdd)); len++; end
    repeat (D) begin exp_q.push_back(bw(1, 1, 1, 1, 0, {bank, 1'b1}, d, m_rdd)); len++; end
    exp_q.push_back(bw(0, 1, 1, 1, 0, {bank, 1'b1}, d, m_rdd));
    len++;
    m_dout = d;
  endtask

  task automatic push_read(input logic [7:0] v);
    repeat (P) exp_q.push_back(bw(1, 0, 1, 0, 0, 2'b00, m_dout, m_rdd));
    m_rdd = v;
    exp_q.push_back(bw(0, 1, 1, 1, 1, 2'b00, m_dout, m_rdd));
  endtask

  // Called and returns at a falling edge.
  task automatic do_write(input logic bank, input logic [7:0] a, input logic [7:0] d,
                          input bit push, output int acc, output int len);
    req_valid = 1'b1;
    req.bank = bank;
    req.address = a;
    req.data = d;
    acc = -1;
    len = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (req_ready) break;
      @(negedge clk_host);
    end
    if (!req_ready) begin
      check_eq("wr_accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_host);
    #1;
    acc = cyc;
    if (push) push_write(bank, a, d, len);
    @(negedge clk_host);
    req_valid = 1'b0;
    req.bank = 1'($urandom);
    req.address = 8'($urandom);
    req.data = 8'($urandom);
  endtask

  task automatic do_read(input logic [7:0] v, output int acc);
    rd_req_valid = 1'b1;
    din = ~v;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (rd_req_ready) break;
      @(negedge clk_host);
    end
    if (!rd_req_ready) begin
      check_eq("rd_accept_timeout", 32'(rd_req_ready), 32'd1);
      rd_req_valid = 1'b0;
      return;
    end
    @(posedge clk_host);
    #1;
    acc = cyc;
    push_read(v);
    @(negedge clk_host);
    rd_req_valid = 1'b0;
    // Only the last strobe cycle carries the real status byte.
    repeat (P - 1) @(negedge clk_host);
    din = v;
    @(negedge clk_host);
    din = ~v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, a4, a5, a6, r1, r2, r3, l1, l2, l3, l4, l5, l6, zacc;

    reset = 1'b1;
    req_valid = 1'b0;
    rd_req_valid = 1'b0;
    req = '0;
    din = 8'h00;
    z_req_valid = 1'b0;
    z_req = '0;
    repeat (3) @(posedge clk_host);
    @(negedge clk_host);
    check_eq("reset_bus", 32'(bw(busy, cs_n, wr_n, rd_n, rd_valid, address, dout, rd_data)),
             32'(bw(0, 1, 1, 1, 0, 2'b00, 8'h00, 8'h00)));
    check_eq("ready_in_reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("ready_after_reset", 32'({req_ready, rd_req_ready}), 32'b11);

    // Full write, then back-to-back writes exercising the address cache key.
    do_write(1'b1, 8'h05, 8'h01, 1'b1, a1, l1);
    do_write(1'b0, 8'hA0, 8'h11, 1'b1, a2, l2);
    check_eq("spacing_w1", 32'(a2 - a1), 32'(l1));
    do_write(1'b0, 8'hA0, 8'h22, 1'b1, a3, l3);
    check_eq("spacing_w2", 32'(a3 - a2), 32'(l2));
    do_write(1'b1, 8'hA0, 8'h33, 1'b1, a4, l4);
    check_eq("spacing_w3", 32'(a4 - a3), 32'(l3));

    do_read(8'hE0, r1);
    check_eq("spacing_w4_rd", 32'(r1 - a4), 32'(l4));

    // Write and read together: write first, read only after the write finishes.
    req_valid = 1'b1;
    req.bank = 1'b0;
    req.address = 8'h5A;
    req.data = 8'hC3;
    rd_req_valid = 1'b1;
    #1;
    check_eq("prio_rd_ready_low", 32'(rd_req_ready), 32'd0);
    check_eq("prio_wr_ready", 32'(req_ready), 32'd1);
    do_write(1'b0, 8'h5A, 8'hC3, 1'b1, a5, l5);
    check_eq("spacing_rd_w5", 32'(a5 - r1), 32'(P + 1));
    check_eq("rd_ready_while_busy", 32'(rd_req_ready), 32'd0);
    do_read(8'h3C, r2);
    check_eq("spacing_w5_rd", 32'(r2 - a5), 32'(l5));

    // Reset during the first data strobe cycle.
    do_write(1'b1, 8'h33, 8'h44, 1'b0, a6, l6);
    repeat (P + A) @(negedge clk_host);
    check_eq("rst_pre_data_stb", 32'({cs_n, wr_n, address}), 32'({1'b0, 1'b0, 2'b11}));
    reset = 1'b1;
    #1;
    check_eq("ready_low_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk_host);
    check_eq("rst_truncate", 32'(bw(busy, cs_n, wr_n, rd_n, rd_valid, address, dout, rd_data)),
             32'(bw(0, 1, 1, 1, 0, 2'b00, 8'h00, 8'h00)));
    reset = 1'b0;
    m_dout = 8'h00;
    m_rdd = 8'h00;
    m_cvld = 1'b0;
    do_write(1'b1, 8'h33, 8'h44, 1'b1, a6, l6);
    do_read(8'h81, r3);
    check_eq("spacing_w6_rd", 32'(r3 - a6), 32'(l6));

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk_host);
    check_eq("trace_drained", 32'(exp_q.size()), 32'd0);

    // Zero-gap instance: strobes adjacent, ready after 2P+1 cycles.
    @(negedge clk_host);
    z_req_valid = 1'b1;
    z_req.bank = 1'b1;
    z_req.address = 8'h12;
    z_req.data = 8'h34;
    #1;
    check_eq("z_ready_idle", 32'(z_req_ready), 32'd1);
    @(posedge clk_host);
    #1;
    zacc = cyc;
    for (int k = 1; k <= 2 * P + 1; k++) begin
      @(negedge clk_host);
      z_req_valid = 1'b0;
      if (k <= P)
        check_eq("z_addr_stb", 32'(bw(z_busy, z_cs_n, z_wr_n, z_rd_n, z_rd_valid, z_address,
                 z_dout, z_rd_data)), 32'(bw(1, 0, 0, 1, 0, 2'b10, 8'h12, 8'h00)));
      else if (k <= 2 * P)
        check_eq("z_data_stb", 32'(bw(z_busy, z_cs_n, z_wr_n, z_rd_n, z_rd_valid, z_address,
                 z_dout, z_rd_data)), 32'(bw(1, 0, 0, 1, 0, 2'b11, 8'h34, 8'h00)));
      else begin
        check_eq("z_idle", 32'(bw(z_busy, z_cs_n, z_wr_n, z_rd_n, z_rd_valid, z_address,
                 z_dout, z_rd_data)), 32'(bw(0, 1, 1, 1, 0, 2'b11, 8'h34, 8'h00)));
        check_eq("z_ready_ret", 32'({z_req_ready, 8'(cyc - zacc)}),
                 32'({1'b1, 8'(2 * P)}));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
